pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised elastic pipeline stage register for the square-root datapath. It replaces the fixed-width, enable-only stage registers between pipeline stages with a WIDTH-bit, valid/ready-handshaked two-entry skid buffer. Each data register has a configurable per-bit reset value, for example the square accumulator that must come up as 1. It sits between any two datapath stages and absorbs one cycle of downstream back-pressure without a combinational ready path.

## Interface
Parameters:
- WIDTH, 13, data width in bits (legal range 1..64).
- RESET_VALUE, 13'h0001, value loaded into both data registers on reset or flush.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears the stage immediately.
- enable  in  1  stage enable; 0 freezes all state.
- flush  in  1  synchronous clear; same end state as reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  main register holds a valid word.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  main register contents.

## Operation
- Storage:
  - main register M, drives out_data.
  - skid register K.
  - state ST ∈ {EMPTY, FULL, SKID}.
- Reset (async, active-high):
  - ST=EMPTY, M=K=RESET_VALUE.
  - out_valid=0, in_ready=1, out_data=RESET_VALUE.
- Output decoding:
  - in_ready = enable & (ST≠SKID).
  - out_valid = enable & (ST≠EMPTY).
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Transitions, evaluated only when enable=1 and flush=0:
  - EMPTY:
    - accept → FULL, M←in_data.
  - FULL:
    - accept & drain → FULL, M←in_data.
    - accept & !drain → SKID, K←in_data.
    - !accept & drain → EMPTY; M holds its value (stale, not cleared).
    - otherwise hold.
  - SKID:
    - drain → FULL, M←K.
    - no accept is possible here (in_ready=0).
- enable=0:
  - no register changes.
  - in_ready and out_valid are forced to 0, so no transfers occur on either side.
  - out_data keeps showing M.
- flush=1 (synchronous, highest priority after reset):
  - next state is EMPTY, M=K=RESET_VALUE.
  - Any concurrent accept or drain is discarded.
  - Applies regardless of enable.
- Data is passed bit-exact. No arithmetic or width conversion.
- in_valid must stay high and in_data stable until accepted. The stage does not check this.

## Timing
- Latency: one cycle from accept to out_valid when ST=EMPTY and enable=1.
- Throughput: one word per cycle with out_ready held high.
- in_ready depends only on registered state and enable. There is no combinational path from out_ready to in_ready.
- Back-pressure: the first stall cycle captures one extra word in K. in_ready falls the cycle after.
- Ordering: words leave in arrival order. The word in K always follows the word in M.
- Reset asserted mid-transfer: any word in M or K is lost. Outputs reach reset values without waiting for a clock edge.
- Reset release: the first accept can occur on the first rising edge after reset deasserts.
- Flush and reset asserted together: reset dominates. The end state is identical either way.

## Structure
- Shared package (pipe_pkg) holds:
  - state encoding constants ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - the default WIDTH.
- Sub-module dffa_vec: WIDTH-bit register with async active-high reset to a RESET_VALUE parameter and a synchronous load enable.
  - Instantiated twice, for M and K.
  - Replaces hand-instantiated per-bit dffa arrays and per-bit set/reset swapping.
- The state register and next-state logic live in the top module.

## Test plan
1. Reset: assert reset mid-cycle with ST=SKID → immediately out_valid=0, in_ready=1, out_data=13'h0001.
2. Streaming: in_valid=1 with data 0x0A,0x0B,0x0C, out_ready=1 → out_data 0x0A,0x0B,0x0C on consecutive cycles, first one cycle after accept.
3. Back-pressure:
   - send 0x10 then 0x11 with out_ready=0 → ST=SKID, in_ready=0, out_data=0x10.
   - raise out_ready → 0x10 then 0x11, no loss or duplication.
4. Enable freeze: ST=FULL with M=0x1FFF, enable=0 for 3 cycles with in_valid=out_ready=1 → M unchanged, no transfers; enable=1 resumes with 0x1FFF delivered first.
5. Flush: ST=SKID with flush=1 and in_valid=1 → next cycle ST=EMPTY, out_data=RESET_VALUE, incoming word dropped.
6. Parameter sweep: WIDTH=1 with RESET_VALUE=1'b0, and WIDTH=32 with RESET_VALUE=32'hDEADBEEF → correct reset values and a random stream delivered in order against a scoreboard model.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Items shared by the elastic pipeline stage and its register sub-module:
//   PIPE_WIDTH - default datapath width of a square-root pipeline stage
//   pipe_st_e  - occupancy state of the two-entry skid stage
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 13;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_st_e;

endpackage

// File: rtl/dffa_vec.sv
// ---------------------------------------------------------------------------
// dffa_vec
// WIDTH-bit register. It resets asynchronously to RESET_VALUE and loads d_i on
// the rising clock edge when load_i is high.
// Ports:
//   clock_i  in  1      clock
//   reset_i  in  1      asynchronous active-high reset to RESET_VALUE
//   load_i   in  1      synchronous load enable
//   d_i      in  WIDTH  next value
//   q_o      out WIDTH  register contents
// ---------------------------------------------------------------------------
module dffa_vec
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= RESET_VALUE;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Elastic valid/ready stage register with a two-entry skid buffer. The main
// register M drives out_data. The skid register K catches the one word that
// arrives during the first cycle of back-pressure. Because in_ready is decoded
// only from registered state and enable, no combinational path runs from
// out_ready to in_ready.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | no valid word; M may hold a stale value
//   ST_FULL  | M holds the next outgoing word
//   ST_SKID  | M holds the oldest word, K the one behind it
//
// Ports:
//   clock      in  1      clock, rising edge
//   reset      in  1      asynchronous active-high reset
//   enable     in  1      0 freezes all state and blocks both handshakes
//   flush      in  1      synchronous clear to the reset state
//   in_valid   in  1      upstream word valid
//   in_ready   out 1      stage accepts a word this cycle
//   in_data    in  WIDTH  upstream word
//   out_valid  out 1      M holds a valid word
//   out_ready  in  1      downstream accepts
//   out_data   out WIDTH  contents of M
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = 13'h0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_st_e         st_q, st_d;
  logic             m_load, k_load;
  logic [WIDTH-1:0] m_d, k_d;
  logic [WIDTH-1:0] m_q, k_q;
  logic             accept, drain;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= ST_EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  // output decode: registered state gated by enable only
  always_comb begin
    in_ready  = enable & (st_q != ST_SKID);
    out_valid = enable & (st_q != ST_EMPTY);
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // next-state and register load control
  always_comb begin
    st_d   = st_q;
    m_load = 1'b0;
    k_load = 1'b0;
    m_d    = in_data;
    k_d    = in_data;
    if (flush) begin
      // flush wins over enable and discards any concurrent handshake
      st_d   = ST_EMPTY;
      m_load = 1'b1;
      k_load = 1'b1;
      m_d    = RESET_VALUE;
      k_d    = RESET_VALUE;
    end else if (enable) begin
      unique case (st_q)
        ST_EMPTY: begin
          if (accept) begin
            st_d   = ST_FULL;
            m_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            m_load = 1'b1;
          end else if (accept) begin
            st_d   = ST_SKID;
            k_load = 1'b1;
          end else if (drain) begin
            // M is left stale on purpose; out_valid already marks it empty
            st_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            st_d   = ST_FULL;
            m_load = 1'b1;
            m_d    = k_q;
          end
        end
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  dffa_vec #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main_reg (
    .clock_i (clock),
    .reset_i (reset),
    .load_i  (m_load),
    .d_i     (m_d),
    .q_o     (m_q)
  );

  dffa_vec #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid_reg (
    .clock_i (clock),
    .reset_i (reset),
    .load_i  (k_load),
    .d_i     (k_d),
    .q_o     (k_q)
  );

  assign out_data = m_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Three stage instances (13-bit default, 1-bit, and 32-bit) share one set of
// control inputs. A FIFO reference model with a capacity of two words predicts
// the outputs of all three instances.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam logic [63:0] RV13 = 64'h0001;
  localparam logic [63:0] RV1  = 64'h0;
  localparam logic [63:0] RV32 = 64'hDEAD_BEEF;
  localparam logic [63:0] MK13 = 64'h1FFF;
  localparam logic [63:0] MK1  = 64'h1;
  localparam logic [63:0] MK32 = 64'hFFFF_FFFF;

  logic        clock, reset, enable, flush, in_valid, out_ready;
  logic [31:0] in_data_w;
  logic [12:0] d13, q13;
  logic [0:0]  d1, q1;
  logic [31:0] d32, q32;
  logic        ir13, ov13, ir1, ov1, ir32, ov32;

  assign d13 = in_data_w[12:0];
  assign d1  = in_data_w[0:0];
  assign d32 = in_data_w;

  pipe_skid_stage u_dut13 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir13), .in_data(d13),
    .out_valid(ov13), .out_ready(out_ready), .out_data(q13)
  );

  pipe_skid_stage #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(q1)
  );

  pipe_skid_stage #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_dut32 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32), .in_data(d32),
    .out_valid(ov32), .out_ready(out_ready), .out_data(q32)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state: the queue of words in flight, oldest first.
  logic [63:0] mq[$];
  logic [63:0] shown_raw;  // last word M held once the queue emptied
  bit          shown_rv;   // M holds the reset value

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [63:0] rv, input logic [63:0] mask);
    if (mq.size() > 0) return mq[0] & mask;
    if (shown_rv) return rv;
    return shown_raw & mask;
  endfunction

  task automatic check_all(input logic ev, input logic er);
    chk("ov13", 64'(ov13), 64'(ev));
    chk("ir13", 64'(ir13), 64'(er));
    chk("q13",  64'(q13),  exp_data(RV13, MK13));
    chk("ov1",  64'(ov1),  64'(ev));
    chk("ir1",  64'(ir1),  64'(er));
    chk("q1",   64'(q1),   exp_data(RV1, MK1));
    chk("ov32", 64'(ov32), 64'(ev));
    chk("ir32", 64'(ir32), 64'(er));
    chk("q32",  64'(q32),  exp_data(RV32, MK32));
  endtask

  // Apply one cycle of inputs: check mid-cycle, then advance the model at the edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic en, input logic fl, output logic acc);
    logic drn;
    int   n;
    in_valid  = iv;
    in_data_w = d;
    out_ready = ordy;
    enable    = en;
    flush     = fl;
    #4;
    n   = mq.size();
    acc = iv && en && (n < 2);
    drn = ordy && en && (n > 0);
    check_all(en && (n > 0), en && (n < 2));
    @(posedge clock);
    if (fl) begin
      mq.delete();
      shown_rv = 1'b1;
    end else begin
      if (drn) begin
        shown_raw = mq.pop_front();
        shown_rv  = 1'b0;
      end
      if (acc) mq.push_back(64'(d));
    end
    #1;
  endtask

  // Reset raised between clock edges; outputs must change without waiting for a clock edge.
  task automatic mid_reset();
    enable = 1'b1;
    flush  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    shown_rv = 1'b1;
    check_all(1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic       a;
    logic       pend_v;
    logic [31:0] pend_d;
    logic       en, fl;

    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data_w = '0;
    shown_raw = '0; shown_rv = 1'b1;
    @(posedge clock);
    #1;
    mid_reset();

    // streaming
    step(1, 32'h0A, 1, 1, 0, a);
    step(1, 32'h0B, 1, 1, 0, a);
    step(1, 32'h0C, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);

    // back-pressure into the skid register, then drain
    step(1, 32'h10, 0, 1, 0, a);
    step(1, 32'h11, 0, 1, 0, a);
    step(1, 32'h12, 0, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);

    // enable freeze with M = 0x1FFF
    step(1, 32'h1FFF, 0, 1, 0, a);
    for (int i = 0; i < 3; i++) step(1, 32'h55, 1, 0, 0, a);
    step(1, 32'h55, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);

    // flush from SKID with an incoming word
    step(1, 32'h20, 0, 1, 0, a);
    step(1, 32'h21, 0, 1, 0, a);
    step(1, 32'h22, 1, 1, 1, a);
    step(0, 32'h0, 1, 1, 0, a);

    // flush with enable low
    step(1, 32'h23, 0, 1, 0, a);
    step(1, 32'h24, 1, 0, 1, a);
    step(0, 32'h0, 1, 1, 0, a);

    // asynchronous reset while in SKID
    step(1, 32'h30, 0, 1, 0, a);
    step(1, 32'h31, 0, 1, 0, a);
    mid_reset();
    step(1, 32'h40, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);

    // random traffic; in_valid and data are held until the word is accepted
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(2) != 0);
        pend_d = $urandom;
      end
      en = ($urandom_range(9) != 0);
      fl = ($urandom_range(39) == 0);
      step(pend_v, pend_d, 1'($urandom_range(1)), en, fl, a);
      if (a || fl) pend_v = 1'b0;
    end
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);
    step(0, 32'h0, 1, 1, 0, a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
